// File: rtl/sap_ram_prog.sv
// Parametrised SAP program/data RAM: synchronous read/write in run mode plus a
// strobe-driven loader (auto-incrementing pointer, full flag) in programming mode.
module sap_ram_prog #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] addr,
    input  logic              CE,
    input  logic              read_write,
    input  logic              run_prog,
    input  logic              prog_auto,
    input  logic              prog_strobe,
    output logic [ADDR_W-1:0] prog_ptr,
    output logic              prog_done,
    output logic              bus_drive,
    output logic [DATA_W-1:0] Y
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PROG,
        ST_FULL
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_q;
    logic [ADDR_W-1:0] r_prog_ptr;
    logic              r_prog_done;
    logic              r_bus_drive;
    logic              r_strobe_q;

    logic              w_str_rise;
    logic              w_in_load;
    logic              w_auto_wr;
    logic              w_man_wr;
    logic              w_run_sel;
    logic              w_run_wr;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;

    // A write only fires on a strobe edge while staying in a loader state.
    assign w_str_rise  = prog_strobe & ~r_strobe_q;
    assign w_in_load   = ((r_state == ST_PROG) || (r_state == ST_FULL)) && !run_prog;
    assign w_auto_wr   = (r_state == ST_PROG) && !run_prog && w_str_rise && prog_auto;
    assign w_man_wr    = w_in_load && w_str_rise && !prog_auto;
    assign w_run_sel   = (r_state == ST_RUN) && run_prog && !CE;
    assign w_run_wr    = w_run_sel && !read_write;
    assign w_mem_we    = !CLR && (w_auto_wr || w_man_wr || w_run_wr);
    assign w_mem_waddr = w_auto_wr ? r_prog_ptr : addr;

    // Storage has no reset so contents survive CLR.
    always_ff @(posedge CLK) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= data_in;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_state     <= ST_RUN;
            r_prog_ptr  <= '0;
            r_prog_done <= 1'b0;
            r_rd_q      <= '0;
            r_bus_drive <= 1'b0;
            r_strobe_q  <= 1'b0;
        end else begin
            r_strobe_q <= prog_strobe;
            case (r_state)
                ST_RUN: begin
                    if (!run_prog) begin
                        r_state     <= ST_PROG;
                        r_prog_ptr  <= '0;
                        r_prog_done <= 1'b0;
                        r_bus_drive <= 1'b0;
                    end else if (w_run_sel && read_write) begin
                        r_rd_q      <= r_mem[addr];
                        r_bus_drive <= 1'b1;
                    end else begin
                        r_bus_drive <= 1'b0;
                    end
                end
                ST_PROG: begin
                    r_bus_drive <= 1'b0;
                    if (run_prog) begin
                        r_state <= ST_RUN;
                    end else if (w_auto_wr) begin
                        r_prog_ptr <= r_prog_ptr + 1'b1;
                        if (r_prog_ptr == LAST_ADDR) begin
                            r_prog_done <= 1'b1;
                            r_state     <= ST_FULL;
                        end
                    end
                end
                ST_FULL: begin
                    r_bus_drive <= 1'b0;
                    if (run_prog) begin
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign prog_ptr  = r_prog_ptr;
    assign prog_done = r_prog_done;
    assign bus_drive = r_bus_drive;
    assign Y         = r_bus_drive ? r_rd_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sap_ram_prog.sv
// Directed bench for sap_ram_prog: default 8x16 instance plus a 16x64 instance.
module tb_sap_ram_prog;

    logic       clk;
    logic       clr, ce, rw, run_prog, prog_auto, strobe;
    logic [7:0] data_in;
    logic [3:0] addr;
    logic [3:0] ptr;
    logic       done, bd;
    wire  [7:0] y;

    logic        w_clr, w_ce, w_rw, w_run, w_auto, w_strobe;
    logic [15:0] w_data;
    logic [5:0]  w_addr;
    logic [5:0]  w_ptr;
    logic        w_done, w_bd;
    wire  [15:0] w_y;

    int n_checks = 0;
    int n_fail   = 0;

    sap_ram_prog dut (
        .CLK(clk), .CLR(clr), .data_in(data_in), .addr(addr), .CE(ce),
        .read_write(rw), .run_prog(run_prog), .prog_auto(prog_auto),
        .prog_strobe(strobe), .prog_ptr(ptr), .prog_done(done),
        .bus_drive(bd), .Y(y)
    );

    sap_ram_prog #(.DATA_W(16), .ADDR_W(6)) dut_w (
        .CLK(clk), .CLR(w_clr), .data_in(w_data), .addr(w_addr), .CE(w_ce),
        .read_write(w_rw), .run_prog(w_run), .prog_auto(w_auto),
        .prog_strobe(w_strobe), .prog_ptr(w_ptr), .prog_done(w_done),
        .bus_drive(w_bd), .Y(w_y)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        strobe = 1'b1; tick();
        strobe = 1'b0; tick();
    endtask

    task automatic test_reset();
        clr = 1'b1; run_prog = 1'b1; ce = 1'b1; rw = 1'b1; prog_auto = 1'b1;
        strobe = 1'b0; data_in = '0; addr = '0;
        w_clr = 1'b1; w_run = 1'b1; w_ce = 1'b1; w_rw = 1'b1; w_auto = 1'b1;
        w_strobe = 1'b0; w_data = '0; w_addr = '0;
        tick(); tick();
        clr = 1'b0; w_clr = 1'b0;
        tick();
        n_checks++; if (bd !== 1'b0) begin n_fail++; $display("FAIL reset_bus_drive: got %b want 0", bd); end
        // An undriven bus reads Z, or 0 where the simulator is two-state.
        n_checks++; if (!(y === 8'hzz || y === 8'h00)) begin n_fail++; $display("FAIL reset_y: got %h want z", y); end
        n_checks++; if (ptr !== 4'd0) begin n_fail++; $display("FAIL reset_ptr: got %0d want 0", ptr); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (w_ptr !== 6'd0 || w_done !== 1'b0) begin n_fail++; $display("FAIL reset_wide: got ptr=%0d done=%b want 0/0", w_ptr, w_done); end
    endtask

    task automatic test_reset_drops_write();
        ce = 1'b0; rw = 1'b0; addr = 4'd9; data_in = 8'h5A; tick();
        clr = 1'b1; data_in = 8'hFF; tick();
        clr = 1'b0; rw = 1'b1; tick();
        n_checks++; if (y !== 8'h5A) begin n_fail++; $display("FAIL clr_drop_write: got %h want 5a", y); end
        ce = 1'b1; tick();
    endtask

    task automatic test_auto_load();
        run_prog = 1'b0; prog_auto = 1'b1; tick();
        for (int i = 0; i < 16; i++) begin
            data_in = 8'(8'h10 + i);
            pulse();
            n_checks++; if (ptr !== 4'(i + 1)) begin n_fail++; $display("FAIL auto_ptr[%0d]: got %0d want %0d", i, ptr, 4'(i + 1)); end
            n_checks++; if (done !== (i == 15)) begin n_fail++; $display("FAIL auto_done[%0d]: got %b want %b", i, done, (i == 15)); end
        end
        data_in = 8'hAA; pulse();
        n_checks++; if (ptr !== 4'd0 || done !== 1'b1) begin n_fail++; $display("FAIL full_ignore: got ptr=%0d done=%b want 0/1", ptr, done); end
    endtask

    task automatic test_run_read();
        run_prog = 1'b1; tick();
        ce = 1'b0; rw = 1'b1; addr = 4'd5; tick();
        n_checks++; if (y !== 8'h15 || bd !== 1'b1) begin n_fail++; $display("FAIL read_5: got y=%h bd=%b want 15/1", y, bd); end
        addr = 4'd0; tick();
        n_checks++; if (y !== 8'h10) begin n_fail++; $display("FAIL read_0: got %h want 10", y); end
        addr = 4'd15; tick();
        n_checks++; if (y !== 8'h1F) begin n_fail++; $display("FAIL read_15: got %h want 1f", y); end
        ce = 1'b1; tick();
        n_checks++; if (bd !== 1'b0 || !(y === 8'hzz || y === 8'h00)) begin n_fail++; $display("FAIL ce_release: got y=%h bd=%b want z/0", y, bd); end
        n_checks++; if (ptr !== 4'd0 || done !== 1'b1) begin n_fail++; $display("FAIL run_hold: got ptr=%0d done=%b want 0/1", ptr, done); end
    endtask

    task automatic test_strobe_edge();
        run_prog = 1'b0; tick();
        n_checks++; if (ptr !== 4'd0 || done !== 1'b0) begin n_fail++; $display("FAIL prog_entry: got ptr=%0d done=%b want 0/0", ptr, done); end
        data_in = 8'h33; strobe = 1'b1;
        repeat (5) tick();
        n_checks++; if (ptr !== 4'd1) begin n_fail++; $display("FAIL held_strobe: got ptr=%0d want 1", ptr); end
        strobe = 1'b0; tick();
        run_prog = 1'b1; tick();
        strobe = 1'b1; tick();
        run_prog = 1'b0; data_in = 8'h44; tick();
        tick(); tick();
        n_checks++; if (ptr !== 4'd0) begin n_fail++; $display("FAIL strobe_at_entry: got ptr=%0d want 0", ptr); end
        strobe = 1'b0; tick();
        strobe = 1'b1; tick();
        n_checks++; if (ptr !== 4'd1) begin n_fail++; $display("FAIL strobe_reedge: got ptr=%0d want 1", ptr); end
        strobe = 1'b0; tick();
    endtask

    task automatic test_manual_and_run_write();
        for (int i = 0; i < 15; i++) begin
            data_in = 8'(8'h60 + i);
            pulse();
        end
        n_checks++; if (ptr !== 4'd0 || done !== 1'b1) begin n_fail++; $display("FAIL refill_full: got ptr=%0d done=%b want 0/1", ptr, done); end
        prog_auto = 1'b0; addr = 4'd3; data_in = 8'h7E; pulse();
        n_checks++; if (ptr !== 4'd0) begin n_fail++; $display("FAIL manual_ptr: got %0d want 0", ptr); end
        prog_auto = 1'b1; data_in = 8'hBB; pulse();
        run_prog = 1'b1; tick();
        ce = 1'b0; rw = 1'b1; addr = 4'd3; tick();
        n_checks++; if (y !== 8'h7E) begin n_fail++; $display("FAIL manual_read_3: got %h want 7e", y); end
        addr = 4'd0; tick();
        n_checks++; if (y !== 8'h44) begin n_fail++; $display("FAIL read_0_reedge: got %h want 44", y); end
        addr = 4'd1; tick();
        n_checks++; if (y !== 8'h60) begin n_fail++; $display("FAIL read_1: got %h want 60", y); end
        rw = 1'b0; addr = 4'd3; data_in = 8'h42; tick();
        n_checks++; if (bd !== 1'b0) begin n_fail++; $display("FAIL run_write_bd: got %b want 0", bd); end
        rw = 1'b1; tick();
        n_checks++; if (y !== 8'h42) begin n_fail++; $display("FAIL run_write_read: got %h want 42", y); end
        ce = 1'b1; tick();
    endtask

    task automatic test_mode_switch_and_reset_mid_load();
        ce = 1'b0; rw = 1'b1; addr = 4'd2; tick();
        n_checks++; if (y !== 8'h61 || bd !== 1'b1) begin n_fail++; $display("FAIL pre_switch_read: got y=%h bd=%b want 61/1", y, bd); end
        run_prog = 1'b0; tick();
        n_checks++; if (bd !== 1'b0 || !(y === 8'hzz || y === 8'h00)) begin n_fail++; $display("FAIL switch_release: got y=%h bd=%b want z/0", y, bd); end
        ce = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_in = 8'(8'hA0 + i);
            pulse();
        end
        n_checks++; if (ptr !== 4'd4) begin n_fail++; $display("FAIL mid_load_ptr: got %0d want 4", ptr); end
        clr = 1'b1; tick();
        n_checks++; if (ptr !== 4'd0 || done !== 1'b0 || bd !== 1'b0) begin n_fail++; $display("FAIL mid_load_clr: got ptr=%0d done=%b bd=%b want 0/0/0", ptr, done, bd); end
        clr = 1'b0; run_prog = 1'b1; tick();
        ce = 1'b0; rw = 1'b1;
        for (int k = 0; k < 4; k++) begin
            addr = 4'(k); tick();
            n_checks++; if (y !== 8'(8'hA0 + k)) begin n_fail++; $display("FAIL retained[%0d]: got %h want %h", k, y, 8'(8'hA0 + k)); end
        end
        addr = 4'd4; tick();
        n_checks++; if (y !== 8'h63) begin n_fail++; $display("FAIL retained_4: got %h want 63", y); end
        ce = 1'b1; tick();
    endtask

    task automatic test_wide_fill();
        w_run = 1'b0; w_auto = 1'b1; tick();
        for (int i = 0; i < 64; i++) begin
            w_data = 16'(16'h1000 + i);
            w_strobe = 1'b1; tick();
            w_strobe = 1'b0; tick();
            if (i == 62) begin
                n_checks++; if (w_done !== 1'b0 || w_ptr !== 6'd63) begin n_fail++; $display("FAIL wide_63: got ptr=%0d done=%b want 63/0", w_ptr, w_done); end
            end
        end
        n_checks++; if (w_done !== 1'b1 || w_ptr !== 6'd0) begin n_fail++; $display("FAIL wide_64: got ptr=%0d done=%b want 0/1", w_ptr, w_done); end
        w_run = 1'b1; tick();
        w_ce = 1'b0; w_rw = 1'b1; w_addr = 6'd63; tick();
        n_checks++; if (w_y !== 16'h103F || w_bd !== 1'b1) begin n_fail++; $display("FAIL wide_read_63: got y=%h bd=%b want 103f/1", w_y, w_bd); end
        w_addr = 6'd0; tick();
        n_checks++; if (w_y !== 16'h1000) begin n_fail++; $display("FAIL wide_read_0: got %h want 1000", w_y); end
        w_ce = 1'b1; tick();
    endtask

    initial begin
        clk = 1'b0;
        test_reset();
        test_reset_drops_write();
        test_auto_load();
        test_run_read();
        test_strobe_edge();
        test_manual_and_run_write();
        test_mode_switch_and_reset_mid_load();
        test_wide_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
